// File: rtl/seg_pkg.sv
// seg_pkg: glyph codes and the glyph-to-segment decoder shared by the seg_marquee block
package seg_pkg;
  localparam logic [4:0] GLYPH_H     = 5'd16;
  localparam logic [4:0] GLYPH_L     = 5'd17;
  localparam logic [4:0] GLYPH_BLANK = 5'd18;
  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [6:0] SEG_ROM [18] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00,
    7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h09, 7'h47
  };
  function automatic logic [6:0] glyph_to_seg(input logic [4:0] g);
    return g <= GLYPH_L ? SEG_ROM[g] : SEG_BLANK;
  endfunction
endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: free-running divider producing a one-cycle tick every TICK_DIV run cycles
module seg_tick_gen #(
  parameter int TICK_DIV = 1200000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] r_cnt;
  assign tick = run & (r_cnt == LAST);
  always_ff @(posedge clock) begin
    if (reset) r_cnt <= '0;
    else if (run) r_cnt <= tick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/seg_marquee.sv
// seg_marquee: scrolling seven-segment marquee with LED sweep; SEG_MARQUEE_BOUNCE_EN selects bounce over circular sweep
module seg_marquee import seg_pkg::*; #(
  parameter int DIGITS   = 4,
  parameter int LEDS     = 10,
  parameter int MSG_LEN  = 20,
  parameter int TICK_DIV = 1200000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       pause,
  input  logic                       dir,
  input  logic                       msg_wr,
  input  logic [$clog2(MSG_LEN)-1:0] msg_addr,
  input  logic [4:0]                 msg_data,
  output logic [DIGITS*7-1:0]        hex,
  output logic [LEDS-1:0]            ledr,
  output logic                       wrap
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int PW = $clog2(LEDS);
  localparam logic [AW:0]   LEN_M  = (AW+1)'(MSG_LEN);
  localparam logic [AW-1:0] LAST_H = AW'(MSG_LEN - 1);
  localparam logic [PW-1:0] LAST_P = PW'(LEDS - 1);
  logic [4:0]          r_msg [MSG_LEN];
  logic [AW-1:0]       r_head;
  logic [PW-1:0]       r_pos;
  logic [LEDS-1:0]     r_ledr;
  logic [7*DIGITS-1:0] r_hex;
  logic                r_wrap;
  logic                w_clr, w_tick, w_adv;
  logic [PW-1:0]       w_pos_nx;
  logic [AW-1:0]       w_head_nx;
  logic [7*DIGITS-1:0] w_seg;
  // idle behaves like reset for everything except the message buffer
  assign w_clr = reset | ~enable;
  seg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock(clock),
    .reset(w_clr),
    .run  (enable & ~pause),
    .tick (w_tick)
  );
`ifdef SEG_MARQUEE_BOUNCE_EN
  logic r_up;
  assign w_pos_nx = r_up ? r_pos + 1'b1 : r_pos - 1'b1;
  assign w_adv    = w_tick & (w_pos_nx == LAST_P | w_pos_nx == '0);
  always_ff @(posedge clock) begin
    if (w_clr) r_up <= 1'b1;
    else if (w_tick) r_up <= w_pos_nx == LAST_P ? 1'b0 : w_pos_nx == '0 ? 1'b1 : r_up;
  end
`else
  assign w_pos_nx = r_pos == LAST_P ? '0 : r_pos + 1'b1;
  assign w_adv    = w_tick & (w_pos_nx == '0);
`endif
  assign w_head_nx = dir ? (r_head == '0 ? LAST_H : r_head - 1'b1)
                         : (r_head == LAST_H ? '0 : r_head + 1'b1);
  // head + offset never exceeds 2*MSG_LEN-2, so one conditional subtract wraps it
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [AW:0]   w_sum;
    logic [AW-1:0] w_idx;
    assign w_sum = {1'b0, r_head} + (AW+1)'(DIGITS - 1 - d);
    assign w_idx = AW'(w_sum >= LEN_M ? w_sum - LEN_M : w_sum);
    assign w_seg[7*d +: 7] = glyph_to_seg(r_msg[w_idx]);
  end
  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_pos  <= '0;
      r_head <= '0;
      r_ledr <= '0;
      r_hex  <= {DIGITS{SEG_BLANK}};
      r_wrap <= 1'b0;
    end else begin
      r_ledr <= LEDS'(1) << r_pos;
      r_hex  <= w_seg;
      r_wrap <= w_adv & (w_head_nx == '0);
      if (w_tick) r_pos <= w_pos_nx;
      if (w_adv) r_head <= w_head_nx;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < MSG_LEN; k++) r_msg[k] <= GLYPH_BLANK;
    end else if (msg_wr && {1'b0, msg_addr} < LEN_M) begin
      r_msg[msg_addr] <= msg_data;
    end
  end
  assign hex  = r_hex;
  assign ledr = r_ledr;
  assign wrap = r_wrap;
endmodule
